// File: rtl/dip_debounce.sv
// DIP switch conditioner: 2-FF synchronizer plus per-bit stability counter
// advanced on tap rising edges; emits debounced value, change strobe, settled flag.
module dip_debounce #(
  parameter int                N_BITS         = 4,
  parameter int                STABLE_SAMPLES = 8,
  parameter logic [N_BITS-1:0] RESET_VAL      = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tap_i,
  input  logic [N_BITS-1:0] din_i,
  output logic [N_BITS-1:0] val_o,
  output logic              changed_o,
  output logic              stable_o
);

  localparam int            CW       = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [N_BITS-1:0] sync1_q;
  logic [N_BITS-1:0] sync2_q;
  logic [N_BITS-1:0] val_q;
  logic [N_BITS-1:0] val_d;
  logic [CW-1:0]     cnt_q [N_BITS];
  logic [CW-1:0]     cnt_d [N_BITS];
  logic              tap_q;
  logic              strobe;
  logic              changed_q;
  logic              changed_d;
  logic              stable_q;
  logic              stable_d;

  assign strobe = tap_i & ~tap_q;

  always_comb begin
    val_d    = val_q;
    stable_d = (sync2_q == val_q);
    for (int i = 0; i < N_BITS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) stable_d = 1'b0;
      if (strobe) begin
        // Any sample agreeing with val throws away the partial count.
        if (sync2_q[i] == val_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i] = '0;
          val_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |(val_d ^ val_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= RESET_VAL;
      sync2_q   <= RESET_VAL;
      tap_q     <= 1'b1;
      val_q     <= RESET_VAL;
      changed_q <= 1'b0;
      stable_q  <= 1'b1;
      for (int i = 0; i < N_BITS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= din_i;
      sync2_q   <= sync1_q;
      tap_q     <= tap_i;
      val_q     <= val_d;
      changed_q <= changed_d;
      stable_q  <= stable_d;
      for (int i = 0; i < N_BITS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign val_o     = val_q;
  assign changed_o = changed_q;
  assign stable_o  = stable_q;

endmodule
